// File: rtl/fp_alu_console.sv
`default_nettype none
// ============================================================================
// Module   : fp_alu_console
// Purpose  : Hex operand/op entry, ALU start/done handshake with timeout,
//            and a paged, registered 7-segment hex display.
// Revision : 1.0
// ============================================================================

module fp_alu_console #(
   parameter int WIDTH   = 32,
   parameter int DIGITS  = 8,
   parameter int TIMEOUT = 255,
   localparam int PAGES  = WIDTH / (4 * DIGITS),
   localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [3:0]            nib_in,
   input  logic                  nib_strobe,
   input  logic                  enter,
   input  logic [1:0]            op_sel,
   input  logic [PW-1:0]         page,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [1:0]            alu_op,
   output logic                  alu_start,
   input  logic                  alu_done,
   input  logic [WIDTH-1:0]      alu_result,
   output logic [7*DIGITS-1:0]   seg,
   output logic [2:0]            state_led,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [2:0] {
      S_ENTER_A = 3'd0,
      S_ENTER_B = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_SHOW    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT - 1);

   state_t                 r_state;
   state_t                 w_state_next;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [1:0]             r_op;
   logic [WIDTH-1:0]       r_result;
   logic [TW-1:0]          r_timer;
   logic [7*DIGITS-1:0]    r_seg;
   logic                   w_timer_last;
   logic [WIDTH-1:0]       w_disp;
   logic [4*DIGITS-1:0]    w_page_val;
   logic                   w_page_ok;
   logic [7*DIGITS-1:0]    w_seg_next;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_timer_last = (r_timer == c_TIMER_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_ENTER_A;
      else          r_state <= w_state_next;
   end

   // A done on the final WAIT cycle takes priority over the timeout.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_ENTER_A: if (enter) w_state_next = S_ENTER_B;
         S_ENTER_B: if (enter) w_state_next = S_ISSUE;
         S_ISSUE:   w_state_next = S_WAIT;
         S_WAIT: begin
            if (alu_done)          w_state_next = S_SHOW;
            else if (w_timer_last) w_state_next = S_ERROR;
         end
         S_SHOW, S_ERROR: if (enter) w_state_next = S_ENTER_A;
         default:   w_state_next = S_ENTER_A;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_timer  <= '0;
      end else begin
         case (r_state)
            S_ENTER_A: begin
               if (nib_strobe) r_a <= {r_a[WIDTH-5:0], nib_in};
               if (enter)      r_b <= '0;
            end
            S_ENTER_B: begin
               if (nib_strobe) r_b  <= {r_b[WIDTH-5:0], nib_in};
               if (enter)      r_op <= op_sel;
            end
            S_ISSUE: r_timer <= '0;
            S_WAIT: begin
               if (alu_done)           r_result <= alu_result;
               else if (!w_timer_last) r_timer  <= r_timer + 1'b1;
            end
            S_SHOW, S_ERROR: if (enter) r_a <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (r_state)
         S_ENTER_A: w_disp = r_a;
         S_SHOW:    w_disp = r_result;
         default:   w_disp = r_b;
      endcase
   end

   // Pages past the last one match nothing and blank the display.
   always_comb begin
      w_page_val = '0;
      w_page_ok  = 1'b0;
      for (int p = 0; p < PAGES; p++) begin
         if (page == PW'(p)) begin
            w_page_val = w_disp[p*4*DIGITS +: 4*DIGITS];
            w_page_ok  = 1'b1;
         end
      end
   end

   always_comb begin
      w_seg_next = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_state == S_ERROR) w_seg_next[7*i +: 7] = 7'h40;
         else if (w_page_ok)     w_seg_next[7*i +: 7] = hex7(w_page_val[4*i +: 4]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_seg <= '0;
      else          r_seg <= w_seg_next;
   end

   assign seg       = r_seg;
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_op    = r_op;
   assign alu_start = (r_state == S_ISSUE);
   assign busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign err       = (r_state == S_ERROR);
   assign state_led = r_state;

endmodule

`default_nettype wire
